// File: rtl/jumpy_pkg.sv
// Shared definitions for the jumpy_hawk game: FSM states, LFSR taps,
// default screen/bird geometry and the BCD score helper.
package jumpy_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        UPDATE = 3'd2,
        FLOOR  = 3'd3,
        DEAD   = 3'd4
    } state_e;

    // Feedback taps at bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int BIRD_X_DEF   = 40;
    localparam int BIRD_W_DEF   = 6;
    localparam int BIRD_H_DEF   = 6;

    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] bcd);
        logic [7:0] res;
        if (bcd == 8'h99) begin
            res = bcd;
        end else if (bcd[3:0] == 4'd9) begin
            res = {bcd[7:4] + 4'd1, 4'd0};
        end else begin
            res = {bcd[7:4], bcd[3:0] + 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/wall_engine_lfsr8.sv
// 8-bit Fibonacci LFSR with seed load and single-step enable; exposes the
// value it would take on the next step so callers can use it in the same cycle.
module lfsr8
    import jumpy_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       step,
    output logic [7:0] lfsr_next
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Next value and register input selection
    always_comb begin
        lfsr_next = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        if (load) begin
            lfsr_d = SEED;
        end else if (step) begin
            lfsr_d = lfsr_next;
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR state register
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/wall_engine.sv
// Scrolling wall engine: moves N walls one per cycle through a shared
// datapath on each frame tick, detects bird hits and keeps a BCD score.
module wall_engine
    import jumpy_pkg::*;
#(
    parameter int         N_WALLS   = 3,
    parameter int         SCREEN_W  = SCREEN_W_DEF,
    parameter int         SCREEN_H  = SCREEN_H_DEF,
    parameter int         WALL_W    = 8,
    parameter int         GAP_H     = 32,
    parameter int         SPACING   = 56,
    parameter int         SPEED     = 1,
    parameter int         BIRD_X    = BIRD_X_DEF,
    parameter int         BIRD_W    = BIRD_W_DEF,
    parameter int         BIRD_H    = BIRD_H_DEF,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   frame_tick,
    input  logic [6:0]             bird_y,
    output logic                   busy,
    output logic                   done,
    output logic                   collision,
    output logic [7:0]             score_bcd,
    output logic [8*N_WALLS-1:0]   wall_x,
    output logic [7*N_WALLS-1:0]   gap_y
);

    // A period too short to clear the screen is widened so walls never pop in on-screen
    localparam int P_INT = (N_WALLS * SPACING < SCREEN_W + WALL_W) ?
                           (SCREEN_W + WALL_W) : (N_WALLS * SPACING);
    localparam int IW    = (N_WALLS > 1) ? $clog2(N_WALLS) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(N_WALLS - 1);
    localparam logic [8:0]    P9       = 9'(P_INT);
    localparam logic [8:0]    SPEED9   = 9'(SPEED);
    localparam logic [8:0]    WALL9    = 9'(WALL_W);
    localparam logic [8:0]    BIRDX9   = 9'(BIRD_X);
    localparam logic [8:0]    BIRDXW9  = 9'(BIRD_X + BIRD_W);
    localparam logic [8:0]    BIRDH9   = 9'(BIRD_H);
    localparam logic [8:0]    SCRH9    = 9'(SCREEN_H);
    localparam logic [8:0]    GAPH9    = 9'(GAP_H);
    localparam logic [6:0]    GAP_INIT = 7'd40;

    function automatic logic [7:0] init_x(input int i);
        return 8'(P_INT - 1 - (N_WALLS - 1 - i) * SPACING);
    endfunction

    state_e        state_q, state_d;
    logic [7:0]    wall_x_q [N_WALLS];
    logic [6:0]    gap_y_q  [N_WALLS];
    logic [IW-1:0] idx_q;
    logic [6:0]    bird_q;
    logic          collision_q;
    logic [7:0]    score_q;

    logic [7:0]    lfsr_next;
    logic          lfsr_step_s;
    logic          respawn_s;
    logic [8:0]    x_old9, x_new9, gap9, bird9;
    logic [6:0]    gap_new_s;
    logic          cross_s, hit_s, floor_hit_s;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .load      (start),
        .step      (lfsr_step_s),
        .lfsr_next (lfsr_next)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; start overrides any state including an in-flight update
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                RUN:     state_d = frame_tick ? UPDATE : RUN;
                UPDATE:  state_d = (idx_q == LAST_IDX) ? FLOOR : UPDATE;
                FLOOR:   state_d = collision_q ? DEAD : RUN;
                DEAD:    state_d = DEAD;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs and packed wall views for the renderer
    always_comb begin
        busy      = (state_q == UPDATE);
        done      = (state_q == FLOOR);
        collision = collision_q;
        score_bcd = score_q;
        wall_x    = '0;
        gap_y     = '0;
        for (int i = 0; i < N_WALLS; i++) begin
            wall_x[8*i +: 8] = wall_x_q[i];
            gap_y[7*i +: 7]  = gap_y_q[i];
        end
    end

    // Shared per-wall update datapath for the wall selected by idx_q
    always_comb begin
        x_old9      = {1'b0, wall_x_q[idx_q]};
        respawn_s   = (x_old9 < SPEED9);
        x_new9      = respawn_s ? (x_old9 + P9 - SPEED9) : (x_old9 - SPEED9);
        gap_new_s   = respawn_s ? 7'(8'd8 + (lfsr_next & 8'h3F)) : gap_y_q[idx_q];
        gap9        = {2'b00, gap_new_s};
        bird9       = {2'b00, bird_q};
        cross_s     = (x_old9 + WALL9 > BIRDX9) && (x_new9 + WALL9 <= BIRDX9);
        hit_s       = (x_new9 < BIRDXW9) && (x_new9 + WALL9 > BIRDX9) &&
                      ((bird9 < gap9) || (bird9 + BIRDH9 > gap9 + GAPH9));
        floor_hit_s = (bird9 + BIRDH9 > SCRH9);
        lfsr_step_s = (state_q == UPDATE) && respawn_s && !start;
    end

    // Wall, score and collision state; floor hit folds in on the last wall so it shows during done
    always_ff @(posedge clk) begin
        if (reset || start) begin
            for (int i = 0; i < N_WALLS; i++) begin
                wall_x_q[i] <= init_x(i);
                gap_y_q[i]  <= GAP_INIT;
            end
            idx_q       <= {IW{1'b0}};
            bird_q      <= 7'd0;
            collision_q <= 1'b0;
            score_q     <= 8'h00;
        end else begin
            case (state_q)
                RUN: begin
                    if (frame_tick) begin
                        idx_q  <= {IW{1'b0}};
                        bird_q <= bird_y;
                    end
                end
                UPDATE: begin
                    wall_x_q[idx_q] <= x_new9[7:0];
                    gap_y_q[idx_q]  <= gap_new_s;
                    if (cross_s && !collision_q) begin
                        score_q <= bcd_inc_sat(score_q);
                    end
                    if (hit_s || ((idx_q == LAST_IDX) && floor_hit_s)) begin
                        collision_q <= 1'b1;
                    end
                    idx_q <= (idx_q == LAST_IDX) ? {IW{1'b0}} : (idx_q + IW'(1));
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wall_engine.sv
// Directed bench for wall_engine with hand-computed wall positions, gaps,
// score values and handshake timing.
module tb_wall_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        frame_tick = 1'b0;
    logic [6:0]  bird_y = 7'd0;
    logic        busy, done, collision;
    logic [7:0]  score_bcd;
    logic [23:0] wall_x;
    logic [20:0] gap_y;

    int total = 0;
    int bad   = 0;

    localparam logic [23:0] LAYOUT0 = {8'd167, 8'd111, 8'd55};
    localparam logic [20:0] GAP0    = {7'd40, 7'd40, 7'd40};

    wall_engine dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .frame_tick (frame_tick),
        .bird_y     (bird_y),
        .busy       (busy),
        .done       (done),
        .collision  (collision),
        .score_bcd  (score_bcd),
        .wall_x     (wall_x),
        .gap_y      (gap_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Issue one tick and return at the negedge of the done cycle
    task automatic do_tick(input logic [6:0] b);
        int n;
        @(negedge clk); frame_tick = 1'b1; bird_y = b;
        @(negedge clk); frame_tick = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) chk("tick_timeout", {31'd0, done}, 32'd1);
    endtask

    // Tick that must be ignored: reports whether any busy/done activity appeared
    task automatic ignored_tick(output logic seen);
        seen = 1'b0;
        @(negedge clk); frame_tick = 1'b1; bird_y = 7'd50;
        @(negedge clk); frame_tick = 1'b0;
        if (busy || done) seen = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (busy || done) seen = 1'b1;
        end
    endtask

    initial begin
        logic       seen;
        logic [6:0] b;
        logic [7:0] x;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_coll", {31'd0, collision}, 32'd0);
        chk("rst_score", {24'd0, score_bcd}, 32'h00);
        chk("rst_wall_x", {8'd0, wall_x}, {8'd0, LAYOUT0});
        chk("rst_gap_y", {11'd0, gap_y}, {11'd0, GAP0});

        ignored_tick(seen);
        chk("idle_tick_ignored", {31'd0, seen}, 32'd0);
        chk("idle_wall_x", {8'd0, wall_x}, {8'd0, LAYOUT0});

        // First tick with detailed handshake timing
        pulse_start;
        @(negedge clk); frame_tick = 1'b1; bird_y = 7'd50;
        @(negedge clk); frame_tick = 1'b0;
        chk("t1_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("t2_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("t3_busy", {31'd0, busy}, 32'd1);
        chk("t3_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_wall_x", {8'd0, wall_x}, {8'd0, 8'd166, 8'd110, 8'd54});
        chk("t4_coll", {31'd0, collision}, 32'd0);
        @(negedge clk);
        chk("t5_done", {31'd0, done}, 32'd0);

        // Walk wall0 through the bird column and into respawn
        for (int k = 2; k <= 56; k++) begin
            do_tick(7'd50);
            if (k == 22) chk("score_before_cross", {24'd0, score_bcd}, 32'h00);
            if (k == 23) chk("score_after_cross", {24'd0, score_bcd}, 32'h01);
            if (k == 55) chk("wall0_at_zero", {24'd0, wall_x[7:0]}, 32'd0);
        end
        chk("respawn_wall_x", {8'd0, wall_x}, {8'd0, 8'd111, 8'd55, 8'd167});
        chk("respawn_gap_y", {11'd0, gap_y}, {11'd0, 7'd40, 7'd40, 7'd18});

        // Wall1 reaches the bird column with the bird above its gap
        for (int k = 57; k <= 65; k++) do_tick(7'd50);
        chk("pre_hit_coll", {31'd0, collision}, 32'd0);
        do_tick(7'd30);
        chk("hit_coll", {31'd0, collision}, 32'd1);
        chk("hit_wall_x", {8'd0, wall_x}, {8'd0, 8'd101, 8'd45, 8'd157});
        chk("hit_score", {24'd0, score_bcd}, 32'h01);
        ignored_tick(seen);
        chk("dead_tick_ignored", {31'd0, seen}, 32'd0);
        chk("dead_wall_x", {8'd0, wall_x}, {8'd0, 8'd101, 8'd45, 8'd157});

        pulse_start;
        chk("restart_coll", {31'd0, collision}, 32'd0);
        chk("restart_score", {24'd0, score_bcd}, 32'h00);
        chk("restart_wall_x", {8'd0, wall_x}, {8'd0, LAYOUT0});
        chk("restart_gap_y", {11'd0, gap_y}, {11'd0, GAP0});

        // Floor hit is visible in the done cycle
        do_tick(7'd117);
        chk("floor_coll", {31'd0, collision}, 32'd1);
        chk("floor_wall_x", {8'd0, wall_x}, {8'd0, 8'd166, 8'd110, 8'd54});

        // Start during the second update cycle aborts the update
        pulse_start;
        @(negedge clk); frame_tick = 1'b1; bird_y = 7'd50;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk);
        chk("abort_partial", {8'd0, wall_x}, {8'd0, 8'd167, 8'd111, 8'd54});
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("abort_wall_x", {8'd0, wall_x}, {8'd0, LAYOUT0});
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("abort_done_next", {31'd0, done}, 32'd0);
        do_tick(7'd50);
        chk("abort_then_tick", {8'd0, wall_x}, {8'd0, 8'd166, 8'd110, 8'd54});

        // Long run keeping the bird inside whichever gap is at the bird column
        pulse_start;
        b = 7'd50;
        for (int k = 1; k <= 5567; k++) begin
            for (int i = 0; i < 3; i++) begin
                x = wall_x[8*i +: 8];
                if (x >= 8'd34 && x <= 8'd46) b = gap_y[7*i +: 7] + 7'd10;
            end
            do_tick(b);
            if (k == 526)  chk("score_09", {24'd0, score_bcd}, 32'h09);
            if (k == 527)  chk("score_10", {24'd0, score_bcd}, 32'h10);
            if (k == 5510) chk("score_98", {24'd0, score_bcd}, 32'h98);
            if (k == 5511) chk("score_99", {24'd0, score_bcd}, 32'h99);
        end
        chk("score_sat", {24'd0, score_bcd}, 32'h99);
        chk("long_run_coll", {31'd0, collision}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
